// File: rtl/serial_add_ctrl_pkg.sv
// serial_add_ctrl_pkg: shared state encoding and counter sizing for the serial adder
package serial_add_ctrl_pkg;
  localparam logic [1:0] IDLE = 2'b00;
  localparam logic [1:0] RUN  = 2'b01;
  localparam logic [1:0] DONE = 2'b10;
  function automatic int cnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction
endpackage

// File: rtl/serial_add_ctrl_if.sv
// serial_add_ctrl_if: operand/result handshake bundle for the serial adder
interface serial_add_ctrl_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;
  logic             busy;
  modport master (
    output in_valid, op_a, op_b, sub, out_ready,
    input  in_ready, out_valid, result, carry_out, overflow, busy
  );
  modport slave (
    input  in_valid, op_a, op_b, sub, out_ready,
    output in_ready, out_valid, result, carry_out, overflow, busy
  );
endinterface

// File: rtl/serial_add_ctrl_full_adder.sv
// FullAdder: one-bit full-adder cell shared by the serial sequencer
module FullAdder (
  input  logic a,
  input  logic b,
  input  logic c,
  output logic sum,
  output logic carry
);
  assign sum   = a ^ b ^ c;
  assign carry = (a & b) | (c & (a ^ b));
endmodule

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl: bit-serial WIDTH-bit add/subtract sequencer around one full adder
module serial_add_ctrl
  import serial_add_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic              clk,
  input logic              rst,
  serial_add_ctrl_if.slave bus
);
  localparam int CW = cnt_width(WIDTH);
  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] res_q;
  logic             cy;
  logic             co_q;
  logic             ovf_q;
  logic             fa_sum;
  logic             fa_carry;
  logic             accept;
  logic             last;
  FullAdder u_fa (
    .a    (a_q[cnt]),
    .b    (b_q[cnt]),
    .c    (cy),
    .sum  (fa_sum),
    .carry(fa_carry)
  );
  assign bus.in_ready  = (state == IDLE) && !rst;
  assign bus.out_valid = state == DONE;
  assign bus.busy      = (state == RUN) || (state == DONE);
  assign bus.result    = res_q;
  assign bus.carry_out = co_q;
  assign bus.overflow  = ovf_q;
  assign accept        = bus.in_valid && bus.in_ready;
  assign last          = cnt == CW'(WIDTH - 1);
  // Sequencer: latch operands (B pre-inverted for subtract), ripple one bit per clock, hold result until taken
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      cy    <= 1'b0;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      co_q  <= 1'b0;
      ovf_q <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        a_q   <= bus.op_a;
        b_q   <= bus.sub ? ~bus.op_b : bus.op_b;
        cy    <= bus.sub;
        cnt   <= '0;
        res_q <= '0;
        co_q  <= 1'b0;
        ovf_q <= 1'b0;
        state <= RUN;
      end
    end else if (state == RUN) begin
      res_q[cnt] <= fa_sum;
      cy         <= fa_carry;
      cnt        <= last ? '0 : cnt + 1'b1;
      if (last) begin
        co_q  <= fa_carry;
        ovf_q <= cy ^ fa_carry;
        state <= DONE;
      end
    end else if (state == DONE) begin
      if (bus.out_ready) state <= IDLE;
    end else begin
      state <= IDLE;
    end
  end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl: directed and random checks of serial_add_ctrl against an arithmetic model
module tb_serial_add_ctrl;
  localparam int W = 8;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  serial_add_ctrl_if #(.WIDTH(W)) bus ();
  serial_add_ctrl #(.WIDTH(W)) dut (.clk(clk), .rst(rst), .bus(bus.slave));
  int n_vec = 0;
  int n_err = 0;
  int edges = 0;
  bit m_active = 1'b0;
  int m_acc = 0;
  logic [W+1:0] m_exp = '0;
  bit b2b_mode = 1'b0;
  bit have_prev = 1'b0;
  int prev_acc = 0;
  int b2b_cnt = 0;
  // returns {carry_out, overflow, result} from plain integer arithmetic
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b, input logic s);
    logic [W:0] u;
    int sa, sb, sr;
    logic c, o;
    sa = int'($signed(a));
    sb = int'($signed(b));
    u  = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    c  = s ? (a >= b) : u[W];
    sr = s ? sa - sb : sa + sb;
    o  = (sr > (2 ** (W - 1)) - 1) || (sr < -(2 ** (W - 1)));
    return {c, o, u[W-1:0]};
  endfunction
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, edges);
    end
  endtask
  always @(posedge clk) edges <= edges + 1;
  // compare DUT against the model every cycle, then predict what the coming edge does
  always @(negedge clk) begin
    logic exp_ov;
    exp_ov = m_active && (edges - m_acc >= W);
    if (edges > 0) begin
      check("in_ready", 32'(bus.in_ready), 32'(!rst && !m_active));
      check("busy", 32'(bus.busy), 32'(m_active));
      check("out_valid", 32'(bus.out_valid), 32'(exp_ov));
      if (exp_ov && bus.out_valid) begin
        check("result", 32'(bus.result), 32'(m_exp[W-1:0]));
        check("overflow", 32'(bus.overflow), 32'(m_exp[W]));
        check("carry_out", 32'(bus.carry_out), 32'(m_exp[W+1]));
      end
    end
    if (!b2b_mode) have_prev = 1'b0;
    if (rst) m_active = 1'b0;
    else if (!m_active && bus.in_valid) begin
      m_active = 1'b1;
      m_acc = edges + 1;
      m_exp = model(bus.op_a, bus.op_b, bus.sub);
      if (b2b_mode) begin
        b2b_cnt++;
        if (have_prev) check("accept_spacing", 32'(m_acc - prev_acc), W + 2);
        prev_acc = m_acc;
        have_prev = 1'b1;
      end
    end else if (exp_ov && bus.out_ready) m_active = 1'b0;
  end
  task automatic wait_ready();
    for (int i = 0; i < 40 && !bus.in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    check("in_ready_timeout", 32'(bus.in_ready), 1);
  endtask
  task automatic wait_valid();
    for (int i = 0; i < 40 && !bus.out_valid; i++) begin
      @(posedge clk);
      #1;
    end
    check("out_valid_timeout", 32'(bus.out_valid), 1);
  endtask
  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic s,
                       input logic [W-1:0] er, input logic ec, input logic eo);
    wait_ready();
    bus.in_valid = 1'b1;
    bus.op_a = a;
    bus.op_b = b;
    bus.sub = s;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.op_a = W'($urandom);
    bus.op_b = W'($urandom);
    bus.sub = ~s;
    wait_valid();
    check("lit_result", 32'(bus.result), 32'(er));
    check("lit_carry", 32'(bus.carry_out), 32'(ec));
    check("lit_overflow", 32'(bus.overflow), 32'(eo));
    if (bus.out_ready) begin
      @(posedge clk);
      #1;
    end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_result", 32'(bus.result), 0);
    check("rst_carry", 32'(bus.carry_out), 0);
    check("rst_overflow", 32'(bus.overflow), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    bus.in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(bus.in_ready), 1);
    check("pin_model_add", 32'(model(8'h5A, 8'h3C, 1'b0)), 32'h196);
    check("pin_model_sub", 32'(model(8'h80, 8'h01, 1'b1)), 32'h37F);
    check("pin_model_sub2", 32'(model(8'h10, 8'h20, 1'b1)), 32'h0F0);
    do_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    do_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
    do_op(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
    do_op(8'h10, 8'h20, 1'b1, 8'hF0, 1'b0, 1'b0);
    do_op(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
    bus.out_ready = 1'b0;
    do_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.op_a = W'($urandom);
      bus.op_b = W'($urandom);
      bus.sub = 1'($urandom);
      @(posedge clk);
      #1;
      check("bp_result", 32'(bus.result), 32'h96);
      check("bp_in_ready", 32'(bus.in_ready), 0);
    end
    bus.op_a = 8'h11;
    bus.op_b = 8'h22;
    bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_idle", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    check("bp_accept_busy", 32'(bus.busy), 1);
    bus.in_valid = 1'b0;
    wait_valid();
    check("bp_new_result", 32'(bus.result), 32'h33);
    @(posedge clk);
    #1;
    wait_ready();
    bus.in_valid = 1'b1;
    bus.op_a = 8'h5A;
    bus.op_b = 8'h3C;
    bus.sub = 1'b0;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_result", 32'(bus.result), 0);
    check("abort_out_valid", 32'(bus.out_valid), 0);
    do_op(8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0, 1'b1);
    b2b_mode = 1'b1;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      bus.op_a = W'($urandom);
      bus.op_b = W'($urandom);
      bus.sub = 1'(k);
      wait_ready();
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    wait_valid();
    @(posedge clk);
    #1;
    b2b_mode = 1'b0;
    check("b2b_accepts", 32'(b2b_cnt), 3);
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #1;
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.op_a = W'($urandom);
      bus.op_b = W'($urandom);
      bus.sub = 1'($urandom);
      bus.out_ready = $urandom_range(0, 3) != 0;
      rst = $urandom_range(0, 199) == 0;
    end
    rst = 1'b0;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (20) @(posedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
